// File: rtl/ola_stitcher.sv
// rtl/ola_stitcher.sv - Hann-windowed overlap-add stitcher into a circular hop-slotted buffer.
// Optional STITCH_SAT_EN: saturate the overlap-add sum instead of wrapping.
module ola_stitcher #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int OVL_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go_in,
  output logic                busy,
  input  logic [DATA_W-1:0]   in_buf_data,
  output logic [ADDR_W-1:0]   in_buf_addr,
  input  logic [COEF_W-1:0]   hann_rom_data,
  output logic [ADDR_W-1:0]   hann_rom_addr,
  input  logic [DATA_W-1:0]   out_rd_data,
  output logic [ADDR_W-1:0]   out_rd_addr,
  output logic [DATA_W-1:0]   out_buf_data,
  output logic [ADDR_W-1:0]   out_buf_addr,
  output logic                out_buf_wren,
  output logic [OVL_LOG2-1:0] window_start,
  output logic                go_out
);

  localparam int N          = 2 ** ADDR_W;
  localparam int HOP        = N >> OVL_LOG2;
  localparam int SLOT_SHIFT = ADDR_W - OVL_LOG2;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] FRESH_IDX = ADDR_W'(N - HOP);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   rd_addr;
  logic [OVL_LOG2-1:0] slot;
  logic [1:0]          drain_cnt;
  logic [ADDR_W-1:0]   slot_base;

  assign slot_base     = {slot, {SLOT_SHIFT{1'b0}}};
  assign in_buf_addr   = idx;
  assign hann_rom_addr = idx;
  assign out_rd_addr   = rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      rd_addr      <= '0;
      slot         <= '0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      go_out       <= 1'b0;
      window_start <= '0;
    end else begin
      go_out <= 1'b0;
      case (state)
        IDLE: begin
          if (go_in) begin
            state   <= RUN;
            idx     <= '0;
            rd_addr <= slot_base;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          idx     <= idx + 1'b1;
          rd_addr <= rd_addr + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd2) begin
            // Publish the hop just completed while go_out is high.
            state        <= DONE;
            go_out       <= 1'b1;
            window_start <= slot;
            slot         <= slot + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic                     p1_valid, p1_fresh;
  logic [ADDR_W-1:0]        p1_addr;
  logic                     p2_valid, p2_fresh;
  logic [ADDR_W-1:0]        p2_addr;
  logic signed [DATA_W-1:0] sample;
  logic [COEF_W-1:0]        coef;
  logic signed [DATA_W-1:0] old;

  logic signed [DATA_W+COEF_W:0] prod;
  logic signed [DATA_W:0]        scaled;
  logic signed [DATA_W:0]        sum;
  logic [DATA_W-1:0]             wr_value;

  // Coefficient is < 1.0, so the shifted product always fits in DATA_W+1 bits.
  assign prod   = sample * $signed({1'b0, coef});
  assign scaled = prod[DATA_W+COEF_W:COEF_W];
  assign sum    = p2_fresh ? scaled : scaled + {old[DATA_W-1], old};

`ifdef STITCH_SAT_EN
  localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};

  always_comb begin
    wr_value = sum[DATA_W-1:0];
    if (sum > SAT_MAX)      wr_value = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) wr_value = SAT_MIN[DATA_W-1:0];
  end
`else
  assign wr_value = sum[DATA_W-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_valid     <= 1'b0;
      p1_fresh     <= 1'b0;
      p1_addr      <= '0;
      p2_valid     <= 1'b0;
      p2_fresh     <= 1'b0;
      p2_addr      <= '0;
      sample       <= '0;
      coef         <= '0;
      old          <= '0;
      out_buf_wren <= 1'b0;
      out_buf_addr <= '0;
      out_buf_data <= '0;
    end else begin
      p1_valid     <= (state == RUN);
      p1_fresh     <= (idx >= FRESH_IDX);
      p1_addr      <= rd_addr;
      p2_valid     <= p1_valid;
      p2_fresh     <= p1_fresh;
      p2_addr      <= p1_addr;
      sample       <= in_buf_data;
      coef         <= hann_rom_data;
      old          <= out_rd_data;
      out_buf_wren <= p2_valid;
      out_buf_addr <= p2_addr;
      if (p2_valid) out_buf_data <= wr_value;
    end
  end

endmodule

// File: tb/tb_ola_stitcher.sv
// tb/tb_ola_stitcher.sv - Self-checking bench for ola_stitcher (N=16, 4 hop slots).
module tb_ola_stitcher;
  localparam int DW = 16, CW = 16, AW = 4, OL = 2;
  localparam int N = 16, HOP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go_in = 1'b0;
  logic          busy;
  logic [DW-1:0] in_buf_data = '0;
  logic [AW-1:0] in_buf_addr;
  logic [CW-1:0] hann_rom_data = '0;
  logic [AW-1:0] hann_rom_addr;
  logic [DW-1:0] out_rd_data = '0;
  logic [AW-1:0] out_rd_addr;
  logic [DW-1:0] out_buf_data;
  logic [AW-1:0] out_buf_addr;
  logic          out_buf_wren;
  logic [OL-1:0] window_start;
  logic          go_out;

  ola_stitcher #(.DATA_W(DW), .COEF_W(CW), .ADDR_W(AW), .OVL_LOG2(OL)) dut (
    .clk(clk), .reset(reset), .go_in(go_in), .busy(busy),
    .in_buf_data(in_buf_data), .in_buf_addr(in_buf_addr),
    .hann_rom_data(hann_rom_data), .hann_rom_addr(hann_rom_addr),
    .out_rd_data(out_rd_data), .out_rd_addr(out_rd_addr),
    .out_buf_data(out_buf_data), .out_buf_addr(out_buf_addr),
    .out_buf_wren(out_buf_wren), .window_start(window_start), .go_out(go_out)
  );

  always #5 clk = ~clk;

  logic [15:0] in_mem [N];
  logic [15:0] rom    [N];
  logic [15:0] out_mem[N];
  logic [15:0] pre_mem[N];
  logic [15:0] exp_mem[N];
  logic        load = 1'b0;

  int cyc = 0;
  int c0  = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    in_buf_data   <= in_mem[in_buf_addr];
    hann_rom_data <= rom[hann_rom_addr];
    out_rd_data   <= out_mem[out_rd_addr];
    if (load) out_mem <= pre_mem;
    else if (out_buf_wren) out_mem[out_buf_addr] <= out_buf_data;
  end

  int nwr, first_wr, last_wr, ngo, go_rel, nbusy, first_busy;
  logic [OL-1:0] ws_at_go;

  always @(negedge clk) begin
    int rel;
    rel = cyc - c0;
    if (out_buf_wren) begin
      if (nwr == 0) first_wr = rel;
      last_wr = rel;
      nwr++;
    end
    if (go_out) begin
      ngo++;
      go_rel = rel;
      ws_at_go = window_start;
    end
    if (busy) begin
      if (nbusy == 0) first_busy = rel;
      nbusy++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fit(input longint v);
    logic [63:0] t;
`ifdef STITCH_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    t = v;
    return t[15:0];
  endfunction

  // Reference: windowed sample = floor(x*c/2^16); overlap region adds, last hop overwrites.
  task automatic model_window(input int slot);
    for (int i = 0; i < N; i++) begin
      int     a;
      longint p, sc, v;
      a  = (slot * HOP + i) % N;
      p  = longint'($signed(in_mem[i])) * longint'(rom[i]);
      sc = p >>> 16;
      v  = (i < N - HOP) ? longint'($signed(exp_mem[a])) + sc : sc;
      exp_mem[a] = fit(v);
    end
  endtask

  task automatic load_out(input logic [15:0] v, input bit rnd);
    for (int i = 0; i < N; i++) begin
      pre_mem[i] = rnd ? 16'($urandom) : v;
      exp_mem[i] = pre_mem[i];
    end
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic fill_in(input logic [15:0] x, input logic [15:0] c, input bit rnd);
    for (int i = 0; i < N; i++) begin
      in_mem[i] = rnd ? 16'($urandom) : x;
      rom[i]    = rnd ? 16'($urandom) : c;
    end
  endtask

  task automatic clear_mon();
    nwr = 0; first_wr = -1; last_wr = -1; ngo = 0; go_rel = -1;
    nbusy = 0; first_busy = -1; ws_at_go = '0;
  endtask

  task automatic run_window(input string tag, input int exp_slot, input int glitch_at);
    clear_mon();
    @(posedge clk); #1;
    c0 = cyc;
    go_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      go_in = (k == glitch_at);
    end
    go_in = 1'b0;
    check({tag, " writes"},     nwr, N);
    check({tag, " first_wr"},   first_wr, 4);
    check({tag, " last_wr"},    last_wr, N + 3);
    check({tag, " go_count"},   ngo, 1);
    check({tag, " go_cycle"},   go_rel, N + 4);
    check({tag, " busy_first"}, first_busy, 1);
    check({tag, " busy_len"},   nbusy, N + 4);
    check({tag, " ws_at_go"},   ws_at_go, exp_slot);
    check({tag, " ws_after"},   window_start, exp_slot);
    model_window(exp_slot);
    for (int i = 0; i < N; i++)
      check($sformatf("%s mem[%0d]", tag, i), out_mem[i], exp_mem[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " busy"},         busy, 0);
    check({tag, " go_out"},       go_out, 0);
    check({tag, " wren"},         out_buf_wren, 0);
    check({tag, " in_buf_addr"},  in_buf_addr, 0);
    check({tag, " rom_addr"},     hann_rom_addr, 0);
    check({tag, " out_rd_addr"},  out_rd_addr, 0);
    check({tag, " out_buf_addr"}, out_buf_addr, 0);
    check({tag, " out_buf_data"}, out_buf_data, 0);
    check({tag, " window_start"}, window_start, 0);
  endtask

  initial begin
    clear_mon();
    fill_in(16'h1000, 16'hFFFF, 1'b0);
    load_out(16'h0000, 1'b0);
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    run_window("w1", 0, -1);
    check("w1 const", out_mem[0], 16'h0FFF);
    run_window("w2", 1, -1);
    check("w2 overlap", out_mem[4], 16'h1FFE);
    check("w2 fresh",   out_mem[0], 16'h0FFF);
    run_window("w3", 2, -1);
    run_window("w4", 3, -1);
    run_window("w5", 0, -1);

    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fill_in(16'h7FFF, 16'hFFFF, 1'b0);
    load_out(16'h7000, 1'b0);
    run_window("sat", 0, -1);
`ifdef STITCH_SAT_EN
    check("sat const", out_mem[0], 16'h7FFF);
`else
    check("sat const", out_mem[0], 16'hEFFE);
`endif
    check("sat fresh", out_mem[12], 16'h7FFE);

    fill_in(16'hE000, 16'h8000, 1'b0);
    load_out(16'h0000, 1'b0);
    run_window("neg", 1, 5);
    check("neg const", out_mem[0], 16'hF000);

    load_out(16'h0000, 1'b1);
    for (int w = 0; w < 4; w++) begin
      fill_in('0, '0, 1'b1);
      run_window($sformatf("rnd%0d", w), (2 + w) % 4, -1);
    end

    clear_mon();
    @(posedge clk); #1;
    c0 = cyc;
    go_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      go_in = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_outputs_zero("abort");
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 2) reset = 1'b0;
    end
    check("abort partial_writes", nwr, 4);
    check("abort no_go", ngo, 0);
    check("abort ws", window_start, 0);

    load_out(16'h0000, 1'b1);
    fill_in('0, '0, 1'b1);
    run_window("recover", 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
